// File: rtl/tx_frame_ctrl.sv
// -----------------------------------------------------------------------------
// tx_frame_ctrl
// Bit-level transmit frame sequencer running on the modulator bit clock.
// It owns the active modulation/baud configuration driven to the clock
// generator and only changes it at an idle symbol boundary. A frame is
// preamble (1,0,1,0,...), SYNC_WORD MSB first, frame_len payload bits pulled
// from a bit source, then zero padding up to a whole symbol.
//
// Ports
//   clk_bitstream      bit clock, one output bit per cycle
//   rst_n              asynchronous active-low reset
//   cfg_update         pulse: latch cfg_mod_type_req / cfg_baud_rate_req
//   cfg_mod_type_req   requested mode (0=QPSK, 1=16QAM)
//   cfg_baud_rate_req  requested baud code
//   start              pulse: request a frame (taken only when idle, nothing pending)
//   frame_len          payload bit count, captured when start is accepted
//   src_data/src_valid payload bit source
//   src_ready          source bit is consumed at the end of this cycle
//   mod_type/baud_rate active configuration
//   bit_out/bit_valid  serial bit stream to the symbol mapper
//   sym_first          bit_out is bit 0 of a symbol
//   busy               frame in progress (including alignment wait)
//   underrun           pulse: payload bit emitted as 0 because src_valid was low
//   done               pulse on the last bit of a frame
// PREAMBLE_BITS must be even and non-zero; SYNC_LEN is 1..16.
// -----------------------------------------------------------------------------
module tx_frame_ctrl #(
    parameter int          PREAMBLE_BITS = 16,
    parameter logic [15:0] SYNC_WORD     = 16'hD391,
    parameter int          SYNC_LEN      = 16,
    parameter int          LEN_W         = 12
) (
    input  logic             clk_bitstream,
    input  logic             rst_n,
    input  logic             cfg_update,
    input  logic             cfg_mod_type_req,
    input  logic [1:0]       cfg_baud_rate_req,
    input  logic             start,
    input  logic [LEN_W-1:0] frame_len,
    input  logic             src_data,
    input  logic             src_valid,
    output logic             src_ready,
    output logic             mod_type,
    output logic [1:0]       baud_rate,
    output logic             bit_out,
    output logic             bit_valid,
    output logic             sym_first,
    output logic             busy,
    output logic             underrun,
    output logic             done
);

    localparam int PRE_W  = $clog2(PREAMBLE_BITS + 1);
    localparam int CNT_W0 = (LEN_W > PRE_W) ? LEN_W : PRE_W;
    localparam int CNT_W  = (CNT_W0 > 5) ? CNT_W0 : 5;

    // state_r names the phase of the bit emitted at the next edge; FIN means
    // the final bit is currently on bit_out.
    typedef enum logic [2:0] {
        ST_IDLE, ST_ALIGN, ST_PRE, ST_SYNC, ST_PAY, ST_PAD, ST_FIN
    } state_t;

    state_t             state_r, state_s, phase_s;
    logic [CNT_W-1:0]   cnt_r, cnt_s, phase_cnt_s;
    logic [LEN_W-1:0]   len_r;
    logic [1:0]         sym_pos_r, sym_pos_nxt_s, sym_pos_d_s, bps_last_s;
    logic               sym_wrap_s, lands_last_s, apply_s, start_ok_s, data_end_s;
    logic               pending_r, req_mod_r;
    logic [1:0]         req_baud_r;
    logic               mod_type_r, bit_out_r, bit_valid_r, sym_first_r;
    logic               busy_r, underrun_r, done_r, src_ready_r;
    logic [1:0]         baud_rate_r;
    logic               bit_s, valid_s, busy_s, underrun_s, done_s, ready_s;
    logic [3:0]         sync_idx_s;

    assign src_ready = src_ready_r;
    assign mod_type  = mod_type_r;
    assign baud_rate = baud_rate_r;
    assign bit_out   = bit_out_r;
    assign bit_valid = bit_valid_r;
    assign sym_first = sym_first_r;
    assign busy      = busy_r;
    assign underrun  = underrun_r;
    assign done      = done_r;

    // Symbol position bookkeeping, config apply and start acceptance.
    always_comb begin
        bps_last_s    = mod_type_r ? 2'd3 : 2'd1;
        sym_wrap_s    = (sym_pos_r == bps_last_s);
        sym_pos_nxt_s = sym_wrap_s ? 2'd0 : (sym_pos_r + 2'd1);
        lands_last_s  = (sym_pos_nxt_s == bps_last_s);
        apply_s       = (state_r == ST_IDLE) && pending_r && sym_wrap_s;
        start_ok_s    = (state_r == ST_IDLE) && start && !pending_r && !cfg_update;
        // apply only happens at a wrap, so the position is 0 either way
        sym_pos_d_s   = apply_s ? 2'd0 : sym_pos_nxt_s;
    end

    // Frame sequencer: next state, counter and the bit emitted at this edge.
    always_comb begin
        state_s    = state_r;
        cnt_s      = cnt_r;
        bit_s      = 1'b0;
        valid_s    = 1'b0;
        busy_s     = busy_r;
        underrun_s = 1'b0;
        done_s     = 1'b0;
        data_end_s = 1'b0;
        // ALIGN emits the first preamble bit on the wrapping edge so that it
        // lands on sym_pos 0.
        if ((state_r == ST_ALIGN) && sym_wrap_s) begin
            phase_s     = ST_PRE;
            phase_cnt_s = '0;
        end else begin
            phase_s     = state_r;
            phase_cnt_s = cnt_r;
        end
        sync_idx_s = 4'(SYNC_LEN - 1) - phase_cnt_s[3:0];
        case (phase_s)
            ST_IDLE: begin
                if (start_ok_s) begin
                    state_s = ST_ALIGN;
                    cnt_s   = '0;
                    busy_s  = 1'b1;
                end else begin
                    state_s = ST_IDLE;
                    busy_s  = 1'b0;
                end
            end
            ST_ALIGN: begin
                state_s = ST_ALIGN;
            end
            ST_PRE: begin
                valid_s = 1'b1;
                bit_s   = ~phase_cnt_s[0];
                if (phase_cnt_s == CNT_W'(PREAMBLE_BITS - 1)) begin
                    state_s = ST_SYNC;
                    cnt_s   = '0;
                end else begin
                    state_s = ST_PRE;
                    cnt_s   = phase_cnt_s + CNT_W'(1);
                end
            end
            ST_SYNC: begin
                valid_s = 1'b1;
                bit_s   = SYNC_WORD[sync_idx_s];
                if (phase_cnt_s == CNT_W'(SYNC_LEN - 1)) begin
                    cnt_s = '0;
                    if (len_r != LEN_W'(0)) begin
                        state_s = ST_PAY;
                    end else begin
                        data_end_s = 1'b1;
                    end
                end else begin
                    cnt_s = phase_cnt_s + CNT_W'(1);
                end
            end
            ST_PAY: begin
                valid_s    = 1'b1;
                bit_s      = src_valid ? src_data : 1'b0;
                underrun_s = ~src_valid;
                if (phase_cnt_s == (CNT_W'(len_r) - CNT_W'(1))) begin
                    data_end_s = 1'b1;
                end else begin
                    cnt_s = phase_cnt_s + CNT_W'(1);
                end
            end
            ST_PAD: begin
                valid_s    = 1'b1;
                data_end_s = 1'b1;
            end
            ST_FIN: begin
                state_s = ST_IDLE;
                cnt_s   = '0;
                busy_s  = 1'b0;
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = '0;
                busy_s  = 1'b0;
            end
        endcase
        // After the last data bit: finish if the symbol is complete, else pad.
        if (data_end_s) begin
            if (lands_last_s) begin
                done_s  = 1'b1;
                state_s = ST_FIN;
            end else begin
                state_s = ST_PAD;
            end
        end else begin
            done_s = 1'b0;
        end
        // src_ready is high for the cycle whose closing edge emits a PAY bit.
        ready_s = (state_s == ST_PAY);
    end

    // Sequencer state, counters and registered stream outputs.
    always_ff @(posedge clk_bitstream or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            cnt_r       <= '0;
            len_r       <= '0;
            sym_pos_r   <= 2'd0;
            bit_out_r   <= 1'b0;
            bit_valid_r <= 1'b0;
            sym_first_r <= 1'b0;
            busy_r      <= 1'b0;
            underrun_r  <= 1'b0;
            done_r      <= 1'b0;
            src_ready_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            cnt_r       <= cnt_s;
            sym_pos_r   <= sym_pos_d_s;
            bit_out_r   <= bit_s;
            bit_valid_r <= valid_s;
            sym_first_r <= valid_s && (sym_pos_d_s == 2'd0);
            busy_r      <= busy_s;
            underrun_r  <= underrun_s;
            done_r      <= done_s;
            src_ready_r <= ready_s;
            if (start_ok_s) begin
                len_r <= frame_len;
            end
        end
    end

    // Configuration request latch and deferred apply at an idle boundary.
    always_ff @(posedge clk_bitstream or negedge rst_n) begin
        if (!rst_n) begin
            pending_r   <= 1'b0;
            req_mod_r   <= 1'b0;
            req_baud_r  <= 2'b00;
            mod_type_r  <= 1'b0;
            baud_rate_r <= 2'b00;
        end else begin
            if (cfg_update) begin
                pending_r  <= 1'b1;
                req_mod_r  <= cfg_mod_type_req;
                req_baud_r <= cfg_baud_rate_req;
            end else if (apply_s) begin
                pending_r <= 1'b0;
            end
            if (apply_s) begin
                mod_type_r  <= req_mod_r;
                baud_rate_r <= req_baud_r;
            end
        end
    end

endmodule

// File: tb/tb_tx_frame_ctrl.sv
// -----------------------------------------------------------------------------
// tb_tx_frame_ctrl
// Directed bench for tx_frame_ctrl. Each frame's expected bit stream is built
// from the frame description and pushed to a scoreboard queue when the frame
// is requested; entries are popped and compared as bit_valid bits appear.
// -----------------------------------------------------------------------------
module tb_tx_frame_ctrl;

    localparam int LEN_W = 12;

    logic             clk_bitstream = 1'b0;
    logic             rst_n = 1'b0;
    logic             cfg_update = 1'b0;
    logic             cfg_mod_type_req = 1'b0;
    logic [1:0]       cfg_baud_rate_req = 2'b00;
    logic             start = 1'b0;
    logic [LEN_W-1:0] frame_len = '0;
    logic             src_data = 1'b0;
    logic             src_valid = 1'b0;
    logic             src_ready, mod_type, bit_out, bit_valid, sym_first;
    logic             busy, underrun, done;
    logic [1:0]       baud_rate;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct packed {
        logic b;
        logic sf;
        logic dn;
        logic ur;
    } exp_t;

    exp_t sb[$];

    tx_frame_ctrl #(
        .PREAMBLE_BITS (16),
        .SYNC_WORD     (16'hD391),
        .SYNC_LEN      (16),
        .LEN_W         (LEN_W)
    ) dut (
        .clk_bitstream     (clk_bitstream),
        .rst_n             (rst_n),
        .cfg_update        (cfg_update),
        .cfg_mod_type_req  (cfg_mod_type_req),
        .cfg_baud_rate_req (cfg_baud_rate_req),
        .start             (start),
        .frame_len         (frame_len),
        .src_data          (src_data),
        .src_valid         (src_valid),
        .src_ready         (src_ready),
        .mod_type          (mod_type),
        .baud_rate         (baud_rate),
        .bit_out           (bit_out),
        .bit_valid         (bit_valid),
        .sym_first         (sym_first),
        .busy              (busy),
        .underrun          (underrun),
        .done              (done)
    );

    always #5 clk_bitstream = ~clk_bitstream;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_bit_valid"}, 32'(bit_valid), 32'd0);
        check({tag, "_bit_out"},   32'(bit_out),   32'd0);
        check({tag, "_sym_first"}, 32'(sym_first), 32'd0);
        check({tag, "_busy"},      32'(busy),      32'd0);
        check({tag, "_src_ready"}, 32'(src_ready), 32'd0);
        check({tag, "_underrun"},  32'(underrun),  32'd0);
        check({tag, "_done"},      32'(done),      32'd0);
    endtask

    // Builds the expected frame, requests it, then checks every emitted bit.
    // cfg_at/start_at inject a cfg_update/start pulse after that many bits.
    task automatic run_frame(input int len, input logic [63:0] pay, input logic [63:0] vmask,
                             input logic exp_mod, input logic [1:0] exp_baud,
                             input int cfg_at, input int start_at, input string tag);
        logic [15:0] sw = 16'hD391;
        logic        qb[$];
        logic        qu[$];
        exp_t        e;
        int          bps, n, nvalid = 0, pidx = 0;
        bit          seen = 1'b0, ended = 1'b0;
        bps = exp_mod ? 4 : 2;
        for (int k = 0; k < 16; k++) begin
            qb.push_back((k % 2) == 0);
            qu.push_back(1'b0);
        end
        for (int k = 0; k < 16; k++) begin
            qb.push_back(sw[15-k]);
            qu.push_back(1'b0);
        end
        for (int k = 0; k < len; k++) begin
            qb.push_back(vmask[k] ? pay[k] : 1'b0);
            qu.push_back(~vmask[k]);
        end
        while ((qb.size() % bps) != 0) begin
            qb.push_back(1'b0);
            qu.push_back(1'b0);
        end
        n = qb.size();
        sb.delete();
        for (int k = 0; k < n; k++) begin
            sb.push_back('{b: qb[k], sf: ((k % bps) == 0), dn: (k == n - 1), ur: qu[k]});
        end
        @(negedge clk_bitstream);
        frame_len = LEN_W'(len);
        start     = 1'b1;
        for (int cyc = 0; cyc < 300 && !ended; cyc++) begin
            @(negedge clk_bitstream);
            start      = 1'b0;
            cfg_update = 1'b0;
            if (bit_valid) begin
                seen = 1'b1;
                nvalid++;
                if (sb.size() == 0) begin
                    check({tag, "_extra_bit"}, 32'(nvalid), 32'(n));
                end else begin
                    e = sb.pop_front();
                    check({tag, "_bit_out"},   32'(bit_out),   32'(e.b));
                    check({tag, "_sym_first"}, 32'(sym_first), 32'(e.sf));
                    check({tag, "_done"},      32'(done),      32'(e.dn));
                    check({tag, "_underrun"},  32'(underrun),  32'(e.ur));
                    check({tag, "_busy"},      32'(busy),      32'd1);
                    check({tag, "_mod_type"},  32'(mod_type),  32'(exp_mod));
                    check({tag, "_baud_rate"}, 32'(baud_rate), 32'(exp_baud));
                end
                if (nvalid == cfg_at) begin
                    cfg_update = 1'b1;
                end
                if (nvalid == start_at) begin
                    start = 1'b1;
                end
            end else if (seen) begin
                ended = 1'b1;
            end
            if (src_ready && pidx < 64) begin
                src_data  = pay[pidx];
                src_valid = vmask[pidx];
                pidx++;
            end else begin
                src_data  = 1'($urandom);
                src_valid = 1'b0;
            end
        end
        start      = 1'b0;
        cfg_update = 1'b0;
        src_valid  = 1'b0;
        check({tag, "_frame_ended"}, 32'(ended),      32'd1);
        check({tag, "_frame_bits"},  32'(nvalid),     32'(n));
        check({tag, "_busy_drop"},   32'(busy),       32'd0);
        check({tag, "_left_in_sb"},  32'(sb.size()),  32'd0);
        check({tag, "_src_taken"},   32'(pidx),       32'(len));
    endtask

    initial begin
        int nv;
        int cnt;

        // 1: reset release and idle
        repeat (3) @(negedge clk_bitstream);
        rst_n = 1'b1;
        @(negedge clk_bitstream);
        check("rst_mod_type", 32'(mod_type), 32'd0);
        check("rst_baud_rate", 32'(baud_rate), 32'd0);
        check_quiet("rst");
        repeat (10) @(negedge clk_bitstream);
        check("idle_mod_type", 32'(mod_type), 32'd0);
        check("idle_baud_rate", 32'(baud_rate), 32'd0);
        check_quiet("idle");

        // 2: QPSK, 8 payload bits 1,1,0,0,...
        run_frame(8, 64'h33, {64{1'b1}}, 1'b0, 2'b00, -1, -1, "t2");

        // 3: switch to 16QAM / baud 11 while idle, then a padded frame
        @(negedge clk_bitstream);
        cfg_mod_type_req  = 1'b1;
        cfg_baud_rate_req = 2'b11;
        cfg_update        = 1'b1;
        @(negedge clk_bitstream);
        cfg_update = 1'b0;
        check("cfg_not_immediate", 32'(mod_type), 32'd0);
        for (int i = 0; i < 10 && mod_type !== 1'b1; i++) @(negedge clk_bitstream);
        check("cfg_mod_type", 32'(mod_type), 32'd1);
        check("cfg_baud_rate", 32'(baud_rate), 32'd3);
        check("cfg_busy", 32'(busy), 32'd0);
        run_frame(6, 64'h2D, {64{1'b1}}, 1'b1, 2'b11, -1, -1, "t3");

        // 4: source gap on payload bits 3 and 4
        run_frame(8, 64'hFF, 64'hFFFF_FFFF_FFFF_FFE7, 1'b1, 2'b11, -1, -1, "t4");

        // 5: cfg_update mid-preamble and a second start mid-frame
        cfg_mod_type_req  = 1'b0;
        cfg_baud_rate_req = 2'b01;
        run_frame(8, 64'h96, {64{1'b1}}, 1'b1, 2'b11, 5, 30, "t5");
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_bitstream);
            if (bit_valid) cnt++;
        end
        check("t5_no_second_frame", 32'(cnt), 32'd0);
        check("t5_cfg_mod_type", 32'(mod_type), 32'd0);
        check("t5_cfg_baud_rate", 32'(baud_rate), 32'd1);

        // 6: empty payload in QPSK
        run_frame(0, 64'h0, 64'h0, 1'b0, 2'b01, -1, -1, "t6");

        // 6b: reset in the middle of the sync word, with a config pending
        repeat (4) @(negedge clk_bitstream);
        cfg_mod_type_req  = 1'b1;
        cfg_baud_rate_req = 2'b10;
        frame_len         = LEN_W'(8);
        start             = 1'b1;
        nv = 0;
        for (int cyc = 0; cyc < 100 && nv < 20; cyc++) begin
            @(negedge clk_bitstream);
            start = 1'b0;
            if (bit_valid) nv++;
            cfg_update = bit_valid && (nv == 10);
        end
        start      = 1'b0;
        cfg_update = 1'b0;
        check("rst_mid_reached", 32'(nv), 32'd20);
        check("rst_mid_pre_baud", 32'(baud_rate), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid_mod_type", 32'(mod_type), 32'd0);
        check("rst_mid_baud_rate", 32'(baud_rate), 32'd0);
        check_quiet("rst_mid");
        @(negedge clk_bitstream);
        rst_n = 1'b1;
        cnt = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk_bitstream);
            if (bit_valid || busy) cnt++;
        end
        check("post_rst_no_resume", 32'(cnt), 32'd0);
        check("post_rst_mod_type", 32'(mod_type), 32'd0);
        check("post_rst_baud_rate", 32'(baud_rate), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
